// File: rtl/dac_playback_ctrl.sv
// dac_playback_ctrl: buffers processor-written samples in a small FIFO and
// paces them onto the 10-bit parallel DAC at a programmable sample rate,
// generating the DAC latch clock and sequencing power-down and wake-up.
module dac_playback_ctrl #(
  parameter int         FIFO_AW  = 5,
  parameter int         WAKE_CYC = 1000,
  parameter logic [9:0] MIDSCALE = 10'h200
) (
  input  logic               Bus2IP_Clk,
  input  logic               Bus2IP_Reset,
  input  logic               cfg_enable,
  input  logic [15:0]        cfg_rate_div,
  input  logic               cfg_twos,
  input  logic               cfg_flush,
  input  logic               underrun_clr,
  input  logic               wr_valid,
  input  logic [0:9]         wr_data,
  output logic               wr_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               underrun,
  output logic               running,
  output logic [0:9]         S_Data,
  output logic               S_DCLKIO,
  output logic               S_Clkout,
  output logic               S_PinMD,
  output logic               S_ClkMD,
  output logic               S_Format,
  output logic               S_PWRDN
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int WW    = (WAKE_CYC < 2) ? 1 : $clog2(WAKE_CYC);
  localparam logic [WW-1:0]      WAKE_LAST = WW'(WAKE_CYC - 1);
  localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, WAKE, RUN} state_t;

  state_t             state, state_next;
  logic [WW-1:0]      wake_cnt;
  logic [15:0]        cnt, div_d, rate_max;
  logic [16:0]        half;
  logic               tick, run_tick, do_pop, do_push, ur_event;
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [FIFO_AW:0]   level_next;
  logic [0:9]         mem [DEPTH];
  logic               dclk;

  // State register; reset always lands in the powered-down idle state
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) state <= IDLE;
    else              state <= state_next;
  end

  // Next-state logic: dropping enable returns to IDLE from anywhere
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cfg_enable) state_next = WAKE;
      WAKE: begin
        if (!cfg_enable)                state_next = IDLE;
        else if (wake_cnt == WAKE_LAST) state_next = RUN;
      end
      RUN:  if (!cfg_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divider tick, FIFO handshakes and next occupancy; flush beats push and pop
  always_comb begin
    rate_max   = (cfg_rate_div == 16'd0) ? 16'd1 : cfg_rate_div;
    half       = ({1'b0, div_d} + 17'd1) >> 1;
    tick       = (state != IDLE) && (cnt == div_d);
    run_tick   = tick && (state == RUN) && cfg_enable;
    do_pop     = run_tick && (fifo_level != '0) && !cfg_flush;
    ur_event   = run_tick && (fifo_level == '0);
    do_push    = wr_valid && wr_ready && !cfg_flush;
    level_next = fifo_level;
    if (cfg_flush)              level_next = '0;
    else if (do_push && !do_pop) level_next = fifo_level + LVL_ONE;
    else if (do_pop && !do_push) level_next = fifo_level - LVL_ONE;
  end

  // Wake-up timer only runs while in WAKE so every wake-up lasts the full time
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset || state != WAKE) wake_cnt <= '0;
    else                               wake_cnt <= wake_cnt + WW'(1);
  end

  // Sample-period counter; a new rate is only picked up at the period boundary
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      cnt   <= 16'd0;
      div_d <= 16'd1;
    end else if (state == IDLE || tick) begin
      cnt   <= 16'd0;
      div_d <= rate_max;
    end else begin
      cnt   <= cnt + 16'd1;
    end
  end

  // Latch clock falls with each data update and rises halfway through the period
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset || state == IDLE || state_next == IDLE) dclk <= 1'b0;
    else if (tick)                                          dclk <= 1'b0;
    else if ({1'b0, cnt} + 17'd1 == half)                   dclk <= 1'b1;
  end

  // Sample storage has no reset; only the pointers and level define content
  always_ff @(posedge Bus2IP_Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and full flag, all registered
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset || cfg_flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      wr_ready   <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      fifo_level <= level_next;
      wr_ready   <= (level_next != LVL_FULL);
    end
  end

  // DAC-facing outputs and status; a new underrun wins over a same-cycle clear
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      S_PWRDN  <= 1'b1;
      S_Data   <= MIDSCALE;
      S_Format <= 1'b0;
      running  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      S_PWRDN  <= (state_next == IDLE);
      running  <= (state_next == RUN);
      S_Format <= cfg_twos;
      if (state_next != RUN) S_Data <= MIDSCALE;
      else if (do_pop)       S_Data <= mem[rd_ptr];
      if (ur_event)          underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  assign S_DCLKIO = dclk;
  assign S_Clkout = dclk;
  assign S_PinMD  = 1'b1;
  assign S_ClkMD  = 1'b0;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// tb_dac_playback_ctrl: scenario tasks drive the playback controller while a
// scoreboard of written samples is popped and compared at each DAC update.
module tb_dac_playback_ctrl;

  localparam int FIFO_AW  = 5;
  localparam int DEPTH    = 32;
  localparam int WAKE_CYC = 8;
  localparam logic [0:9] MID = 10'h200;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_enable, cfg_twos, cfg_flush, underrun_clr, wr_valid;
  logic [15:0]      cfg_rate_div;
  logic [0:9]       wr_data;
  logic             wr_ready, underrun, running;
  logic [FIFO_AW:0] fifo_level;
  logic [0:9]       S_Data;
  logic             S_DCLKIO, S_Clkout, S_PinMD, S_ClkMD, S_Format, S_PWRDN;

  int         checks = 0;
  int         errors = 0;
  logic [0:9] exp_q[$];
  int         exp_level = 0;
  logic       exp_ur = 1'b0;
  logic [0:9] last_data = MID;
  logic       prev_dclk = 1'b0;
  logic       prev_run = 1'b0;
  logic       fall_now = 1'b0;
  int         cycle = 0;
  int         last_fall = -1;
  int         run_entry = 0;
  int         pop_count = 0;

  dac_playback_ctrl #(
    .FIFO_AW(FIFO_AW), .WAKE_CYC(WAKE_CYC), .MIDSCALE(10'h200)
  ) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(reset), .cfg_enable(cfg_enable),
    .cfg_rate_div(cfg_rate_div), .cfg_twos(cfg_twos), .cfg_flush(cfg_flush),
    .underrun_clr(underrun_clr), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_level(fifo_level), .underrun(underrun),
    .running(running), .S_Data(S_Data), .S_DCLKIO(S_DCLKIO),
    .S_Clkout(S_Clkout), .S_PinMD(S_PinMD), .S_ClkMD(S_ClkMD),
    .S_Format(S_Format), .S_PWRDN(S_PWRDN)
  );

  // Free-running bus clock
  always #5 clk = ~clk;

  // One clock: advance, update the scoreboard model and check the monitored outputs
  task automatic step();
    int d;
    int lvl_pre;
    logic popped;
    logic [0:9] e;
    @(posedge clk); #1;
    cycle++;
    d = (cfg_rate_div == 16'd0) ? 1 : int'(cfg_rate_div);
    lvl_pre = exp_level;
    popped = 1'b0;
    fall_now = 1'b0;
    if (reset) begin
      exp_q.delete();
      exp_level = 0;
      exp_ur = 1'b0;
      last_fall = -1;
      prev_dclk = 1'b0;
      prev_run = 1'b0;
    end else begin
      if (!prev_run && running) begin
        run_entry = cycle;
        last_fall = -1;
        last_data = MID;
      end
      if (underrun_clr) exp_ur = 1'b0;
      if (prev_run && running && prev_dclk && !S_DCLKIO) begin
        fall_now = 1'b1;
        checks++;
        if (last_fall < 0) begin
          if (cycle - run_entry > d + 1)
            $display("[TB] FAIL first_pop_latency: got %0d clocks, limit %0d", cycle - run_entry, d + 1);
        end else if (cycle - last_fall != d + 1) begin
          $display("[TB] FAIL sample_period: got %0d clocks, expected %0d", cycle - last_fall, d + 1);
        end
        if (last_fall >= 0 || cycle - run_entry > d + 1) if (last_fall < 0 || cycle - last_fall != d + 1) errors++;
        last_fall = cycle;
        if (lvl_pre > 0 && !cfg_flush) begin
          e = exp_q.pop_front();
          popped = 1'b1;
          pop_count++;
          checks++;
          if (S_Data !== e) begin
            errors++;
            $display("[TB] FAIL sample_data: got %h expected %h", S_Data, e);
          end
          last_data = e;
        end else begin
          checks++;
          if (S_Data !== last_data) begin
            errors++;
            $display("[TB] FAIL hold_data: got %h expected %h", S_Data, last_data);
          end
          if (lvl_pre == 0) exp_ur = 1'b1;
        end
      end
      if (prev_run && running && !prev_dclk && S_DCLKIO && last_fall >= 0) begin
        checks++;
        if (cycle - last_fall != (d + 1) / 2) begin
          errors++;
          $display("[TB] FAIL dclk_rise: got %0d clocks after update, expected %0d", cycle - last_fall, (d + 1) / 2);
        end
      end
      if (cfg_flush) begin
        exp_level = 0;
        exp_q.delete();
      end else begin
        if (popped) exp_level--;
        if (wr_valid && lvl_pre < DEPTH) begin
          exp_q.push_back(wr_data);
          exp_level++;
        end
      end
      prev_dclk = S_DCLKIO;
      prev_run = running;
    end
    checks++;
    if (fifo_level !== (FIFO_AW+1)'(exp_level)) begin
      errors++;
      $display("[TB] FAIL fifo_level: got %0d expected %0d", fifo_level, exp_level);
    end
    checks++;
    if (wr_ready !== (exp_level != DEPTH)) begin
      errors++;
      $display("[TB] FAIL wr_ready: got %b expected %b", wr_ready, exp_level != DEPTH);
    end
    checks++;
    if (underrun !== exp_ur) begin
      errors++;
      $display("[TB] FAIL underrun: got %b expected %b", underrun, exp_ur);
    end
  endtask

  // Drive one sample write for a single clock
  task automatic applyStimulus(input logic [0:9] d);
    wr_valid = 1'b1;
    wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  // Bounded wait until the scoreboard has seen n pops
  task automatic run_until_pops(input int n, input int budget);
    int k;
    k = 0;
    while (pop_count < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (pop_count < n) begin
      errors++;
      $display("[TB] FAIL pop_timeout: got %0d pops expected %0d", pop_count, n);
    end
  endtask

  // Bounded wait for the next DAC update in RUN
  task automatic run_until_fall(input int budget);
    int k;
    k = 0;
    fall_now = 1'b0;
    while (!fall_now && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (!fall_now) begin
      errors++;
      $display("[TB] FAIL tick_timeout: got no update within %0d clocks", budget);
    end
  endtask

  // Check a single-bit output against its expected value
  task automatic test_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    test_bit("reset_pwrdn", S_PWRDN, 1'b1);
    test_bit("reset_dclk", S_DCLKIO, 1'b0);
    test_bit("reset_clkout", S_Clkout, 1'b0);
    test_bit("reset_format", S_Format, 1'b0);
    test_bit("reset_running", running, 1'b0);
    test_bit("pinmd", S_PinMD, 1'b1);
    test_bit("clkmd", S_ClkMD, 1'b0);
    checks++;
    if (S_Data !== MID) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected %h", S_Data, MID);
    end
  endtask

  task automatic test_playback();
    cfg_rate_div = 16'd3;
    cfg_twos = 1'b1;
    step();
    test_bit("format", S_Format, 1'b1);
    applyStimulus(10'h001);
    applyStimulus(10'h3FF);
    applyStimulus(10'h155);
    cfg_enable = 1'b1;
    step();
    test_bit("wake_pwrdn", S_PWRDN, 1'b0);
    test_bit("wake_running", running, 1'b0);
    repeat (WAKE_CYC - 1) step();
    test_bit("wake_still", running, 1'b0);
    checks++;
    if (S_Data !== MID) begin
      errors++;
      $display("[TB] FAIL wake_data: got %h expected %h", S_Data, MID);
    end
    step();
    test_bit("run_entry", running, 1'b1);
    pop_count = 0;
    run_until_pops(3, 40);
    test_bit("no_underrun_yet", underrun, 1'b0);
    run_until_fall(10);
    test_bit("underrun_set", underrun, 1'b1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    test_bit("underrun_clr", underrun, 1'b0);
    run_until_fall(10);
    test_bit("underrun_again", underrun, 1'b1);
    cfg_enable = 1'b0;
    step();
    test_bit("idle_pwrdn", S_PWRDN, 1'b1);
  endtask

  task automatic test_full();
    cfg_flush = 1'b1;
    step();
    cfg_flush = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(10'(i * 37 + 5));
      if (i == DEPTH - 1) begin
        test_bit("full_ready", wr_ready, 1'b0);
        checks++;
        if (fifo_level !== 6'd32) begin
          errors++;
          $display("[TB] FAIL full_level: got %0d expected 32", fifo_level);
        end
      end
    end
    checks++;
    if (fifo_level !== 6'd32) begin
      errors++;
      $display("[TB] FAIL overflow_level: got %0d expected 32", fifo_level);
    end
    cfg_flush = 1'b1;
    step();
    cfg_flush = 1'b0;
    test_bit("flush_ready", wr_ready, 1'b1);
    checks++;
    if (fifo_level !== 6'd0) begin
      errors++;
      $display("[TB] FAIL flush_level: got %0d expected 0", fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    cfg_rate_div = 16'd0;
    for (int i = 0; i < 8; i++) applyStimulus(10'(i * 61 + 3));
    cfg_enable = 1'b1;
    pop_count = 0;
    run_until_pops(3, 60);
    checks++;
    if (fifo_level !== 6'd5) begin
      errors++;
      $display("[TB] FAIL level_before_pushpop: got %0d expected 5", fifo_level);
    end
    step();
    applyStimulus(10'h2AA);
    test_bit("pushpop_tick", fall_now, 1'b1);
    checks++;
    if (fifo_level !== 6'd5) begin
      errors++;
      $display("[TB] FAIL pushpop_level: got %0d expected 5", fifo_level);
    end
    run_until_pops(9, 60);
    cfg_enable = 1'b0;
    step();
  endtask

  task automatic test_disable_resume();
    cfg_rate_div = 16'd3;
    for (int i = 0; i < 12; i++) applyStimulus(10'(i * 83 + 17));
    cfg_enable = 1'b1;
    pop_count = 0;
    run_until_pops(2, 60);
    checks++;
    if (fifo_level !== 6'd10) begin
      errors++;
      $display("[TB] FAIL queued_level: got %0d expected 10", fifo_level);
    end
    cfg_enable = 1'b0;
    step();
    test_bit("disable_pwrdn", S_PWRDN, 1'b1);
    test_bit("disable_running", running, 1'b0);
    checks++;
    if (S_Data !== MID) begin
      errors++;
      $display("[TB] FAIL disable_data: got %h expected %h", S_Data, MID);
    end
    repeat (5) step();
    checks++;
    if (fifo_level !== 6'd10) begin
      errors++;
      $display("[TB] FAIL retained_level: got %0d expected 10", fifo_level);
    end
    cfg_enable = 1'b1;
    step();
    test_bit("rewake_pwrdn", S_PWRDN, 1'b0);
    test_bit("rewake_running", running, 1'b0);
    pop_count = 0;
    run_until_pops(10, 120);
    cfg_enable = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 4; i++) applyStimulus(10'(i * 5 + 900));
    cfg_enable = 1'b1;
    pop_count = 0;
    run_until_pops(1, 40);
    reset = 1'b1;
    cfg_enable = 1'b0;
    step();
    test_bit("midrun_pwrdn", S_PWRDN, 1'b1);
    test_bit("midrun_running", running, 1'b0);
    test_bit("midrun_dclk", S_DCLKIO, 1'b0);
    checks++;
    if (S_Data !== MID) begin
      errors++;
      $display("[TB] FAIL midrun_data: got %h expected %h", S_Data, MID);
    end
    reset = 1'b0;
    step();
  endtask

  // Scenario sequence and summary
  initial begin
    reset = 1'b1;
    cfg_enable = 1'b0;
    cfg_rate_div = 16'd3;
    cfg_twos = 1'b0;
    cfg_flush = 1'b0;
    underrun_clr = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    test_reset();
    test_playback();
    test_full();
    test_back_to_back();
    test_disable_resume();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
